// File: rtl/speed_ctrl_pkg.sv
// Shared types and saturating arithmetic for the front-panel speed controller.
package speed_ctrl_pkg;

  localparam int SPEED_W = 4;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } mode_t;

  localparam speed_t SPEED_MAX = 4'd15;
  localparam speed_t SPEED_MIN = 4'd0;

  function automatic speed_t sat_inc(input speed_t v);
    speed_t r;
    if (v == SPEED_MAX) r = v;
    else                r = v + 4'd1;
    return r;
  endfunction

  function automatic speed_t sat_dec(input speed_t v);
    speed_t r;
    if (v == SPEED_MIN) r = v;
    else                r = v - 4'd1;
    return r;
  endfunction

  function automatic speed_t clamp_speed(input speed_t v, input speed_t lo, input speed_t hi);
    speed_t r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter and press pulse.
// The press pulse is registered together with the accepted level turning high.
module btn_debounce #(
  parameter int unsigned CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise, count consecutive disagreeing cycles, flip level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= ~level_r;
          cnt_r   <= {CNT_W{1'b0}};
          press_r <= ~level_r;
        end else begin
          cnt_r   <= cnt_r + CNT_ONE;
          press_r <= 1'b0;
        end
      end else begin
        cnt_r   <= {CNT_W{1'b0}};
        press_r <= 1'b0;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/speed_ctrl.sv
// Front-panel speed controller: debounced buttons step speed manually, or a
// sweep ramps it between two bounds paced by edges of the counter's toggle.
module speed_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned DWELL_TOGGLES   = 8,
  parameter speed_t      RESET_SPEED     = 4'd8,
  parameter speed_t      SWEEP_MIN       = 4'd1,
  parameter speed_t      SWEEP_MAX       = 4'd15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_mode,
  input  logic         toggle,
  output logic [3:0]   speed,
  output logic [1:0]   mode,
  output logic         speed_changed
);

  if (SWEEP_MIN >= SWEEP_MAX) begin : g_bad_sweep_bounds
    $error("speed_ctrl: SWEEP_MIN must be below SWEEP_MAX");
  end
  if (DWELL_TOGGLES < 1) begin : g_bad_dwell
    $error("speed_ctrl: DWELL_TOGGLES must be at least 1");
  end

  localparam int DW_W = (DWELL_TOGGLES > 1) ? $clog2(DWELL_TOGGLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TOGGLES - 1);
  localparam logic [DW_W-1:0] DWELL_ONE  = DW_W'(1);
  localparam logic [DW_W-1:0] DWELL_ZERO = {DW_W{1'b0}};

  logic press_up_s, press_down_s, press_mode_s;
  logic level_up_s, level_down_s, level_mode_s;
  logic unused_levels_s;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(level_up_s), .press(press_up_s)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(level_down_s), .press(press_down_s)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .raw(btn_mode), .level(level_mode_s), .press(press_mode_s)
  );

  // Accepted levels are only of interest for debug probing.
  assign unused_levels_s = ^{level_up_s, level_down_s, level_mode_s};

  speed_t          speed_r, speed_nx_s;
  mode_t           mode_r, mode_nx_s;
  logic [DW_W-1:0] dwell_r, dwell_nx_s;
  logic            speed_changed_r;
  logic            toggle_d_r;
  logic            tog_edge_s;

  assign tog_edge_s = toggle ^ toggle_d_r;

  // Next mode/speed/dwell; a mode press outranks up/down and any dwell step.
  always_comb begin
    speed_nx_s = speed_r;
    mode_nx_s  = mode_r;
    dwell_nx_s = dwell_r;
    case (mode_r)
      MANUAL: begin
        if (press_mode_s) begin
          if (speed_r >= SWEEP_MAX) mode_nx_s = SWEEP_DOWN;
          else                      mode_nx_s = SWEEP_UP;
          speed_nx_s = clamp_speed(speed_r, SWEEP_MIN, SWEEP_MAX);
          dwell_nx_s = DWELL_ZERO;
        end else if (press_up_s && !press_down_s) begin
          speed_nx_s = sat_inc(speed_r);
        end else if (press_down_s && !press_up_s) begin
          speed_nx_s = sat_dec(speed_r);
        end else begin
          speed_nx_s = speed_r;
        end
      end
      SWEEP_UP: begin
        if (press_mode_s) begin
          mode_nx_s  = MANUAL;
          dwell_nx_s = DWELL_ZERO;
        end else if (tog_edge_s) begin
          if (dwell_r == DWELL_LAST) begin
            dwell_nx_s = DWELL_ZERO;
            if (speed_r >= SWEEP_MAX - 4'd1) begin
              speed_nx_s = SWEEP_MAX;
              mode_nx_s  = SWEEP_DOWN;
            end else begin
              speed_nx_s = speed_r + 4'd1;
            end
          end else begin
            dwell_nx_s = dwell_r + DWELL_ONE;
          end
        end else begin
          dwell_nx_s = dwell_r;
        end
      end
      SWEEP_DOWN: begin
        if (press_mode_s) begin
          mode_nx_s  = MANUAL;
          dwell_nx_s = DWELL_ZERO;
        end else if (tog_edge_s) begin
          if (dwell_r == DWELL_LAST) begin
            dwell_nx_s = DWELL_ZERO;
            if (speed_r <= SWEEP_MIN + 4'd1) begin
              speed_nx_s = SWEEP_MIN;
              mode_nx_s  = SWEEP_UP;
            end else begin
              speed_nx_s = speed_r - 4'd1;
            end
          end else begin
            dwell_nx_s = dwell_r + DWELL_ONE;
          end
        end else begin
          dwell_nx_s = dwell_r;
        end
      end
      default: begin
        mode_nx_s  = MANUAL;
        dwell_nx_s = DWELL_ZERO;
      end
    endcase
  end

  // State registers; speed_changed is registered alongside the speed it flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_r         <= RESET_SPEED;
      mode_r          <= MANUAL;
      dwell_r         <= DWELL_ZERO;
      speed_changed_r <= 1'b0;
      toggle_d_r      <= 1'b0;
    end else begin
      speed_r         <= speed_nx_s;
      mode_r          <= mode_nx_s;
      dwell_r         <= dwell_nx_s;
      speed_changed_r <= (speed_nx_s != speed_r);
      toggle_d_r      <= toggle;
    end
  end

  assign speed         = speed_r;
  assign mode          = mode_r;
  assign speed_changed = speed_changed_r;

endmodule

// File: tb/tb_speed_ctrl.sv
// Bench for speed_ctrl with DEBOUNCE_CYCLES=4, DWELL_TOGGLES=2: vector table,
// hand-written corner sequences and random operations against a reference model.
module tb_speed_ctrl;

  localparam int OP_UP   = 0;
  localparam int OP_DOWN = 1;
  localparam int OP_MODE = 2;
  localparam int OP_BOTH = 3;
  localparam int OP_TOG  = 4;
  localparam int DWELL   = 2;

  typedef struct {
    int op;
    int reps;
    int exp_speed;
    int exp_mode;
    int exp_pulses;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_mode = 1'b0;
  logic       toggle = 1'b0;
  logic [3:0] speed;
  logic [1:0] mode;
  logic       speed_changed;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model state, in plain integers.
  int m_speed = 8;
  int m_mode = 0;
  int m_dwell = 0;
  int m_pulses = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  speed_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_TOGGLES(2),
    .RESET_SPEED(4'd8),
    .SWEEP_MIN(4'd1),
    .SWEEP_MAX(4'd15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_mode(btn_mode),
    .toggle(toggle),
    .speed(speed),
    .mode(mode),
    .speed_changed(speed_changed)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every cycle: a pulse must appear exactly when speed took a new value.
  logic [3:0] prev_speed = 4'd0;
  bit         prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (speed_changed) pulse_cnt++;
      if (prev_valid) check("pulse_vs_change", int'(speed_changed), int'(speed != prev_speed));
      prev_speed = speed;
      prev_valid = 1'b1;
    end
  end

  task automatic m_set(input int s);
    if (s != m_speed) m_pulses++;
    m_speed = s;
  endtask

  task automatic model_up();
    if (m_mode == 0 && m_speed < 15) m_set(m_speed + 1);
  endtask

  task automatic model_down();
    if (m_mode == 0 && m_speed > 0) m_set(m_speed - 1);
  endtask

  task automatic model_mode();
    if (m_mode == 0) begin
      m_mode = (m_speed >= 15) ? 2 : 1;
      if (m_speed < 1) m_set(1);
    end else begin
      m_mode = 0;
    end
    m_dwell = 0;
  endtask

  task automatic model_tog();
    if (m_mode != 0) begin
      m_dwell++;
      if (m_dwell == DWELL) begin
        m_dwell = 0;
        if (m_mode == 1) begin
          m_set(m_speed + 1);
          if (m_speed == 15) m_mode = 2;
        end else begin
          m_set(m_speed - 1);
          if (m_speed == 1) m_mode = 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_speed = 8;
    m_mode  = 0;
    m_dwell = 0;
  endtask

  task automatic press(input bit u, input bit d, input bit m);
    @(negedge clk);
    btn_up   = u;
    btn_down = d;
    btn_mode = m;
    repeat (10) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_unit(input int op);
    case (op)
      OP_UP:   begin press(1'b1, 1'b0, 1'b0); model_up();   end
      OP_DOWN: begin press(1'b0, 1'b1, 1'b0); model_down(); end
      OP_MODE: begin press(1'b0, 1'b0, 1'b1); model_mode(); end
      OP_BOTH: begin press(1'b1, 1'b1, 1'b0); end
      default: begin
        @(negedge clk);
        toggle = ~toggle;
        repeat (2) @(negedge clk);
        model_tog();
      end
    endcase
  endtask

  task automatic add_vec(input int op, input int reps, input int s, input int m, input int p);
    vec_t v;
    v.op = op; v.reps = reps; v.exp_speed = s; v.exp_mode = m; v.exp_pulses = p;
    vecs.push_back(v);
  endtask

  initial begin
    int p0;
    int mp0;
    int cyc;
    int h;
    int l;

    add_vec(OP_DOWN, 7,  2, 0, 7);
    add_vec(OP_DOWN, 1,  1, 0, 1);
    add_vec(OP_DOWN, 1,  0, 0, 1);
    add_vec(OP_DOWN, 1,  0, 0, 0);
    add_vec(OP_UP,   15, 15, 0, 15);
    add_vec(OP_UP,   1,  15, 0, 0);
    add_vec(OP_BOTH, 1,  15, 0, 0);
    add_vec(OP_DOWN, 2,  13, 0, 2);
    add_vec(OP_BOTH, 1,  13, 0, 0);
    add_vec(OP_MODE, 1,  13, 1, 0);
    add_vec(OP_TOG,  2,  14, 1, 1);
    add_vec(OP_UP,   1,  14, 1, 0);
    add_vec(OP_TOG,  2,  15, 2, 1);
    add_vec(OP_TOG,  2,  14, 2, 1);
    add_vec(OP_TOG,  24, 2,  2, 12);
    add_vec(OP_TOG,  2,  1,  1, 1);
    add_vec(OP_TOG,  2,  2,  1, 1);
    add_vec(OP_MODE, 1,  2,  0, 0);
    add_vec(OP_DOWN, 2,  0,  0, 2);
    add_vec(OP_MODE, 1,  1,  1, 1);
    add_vec(OP_MODE, 1,  1,  0, 0);
    add_vec(OP_UP,   14, 15, 0, 14);
    add_vec(OP_MODE, 1,  15, 2, 0);
    add_vec(OP_TOG,  2,  14, 2, 1);
    add_vec(OP_MODE, 1,  14, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_speed", int'(speed), 8);
    check("reset_mode", int'(mode), 0);
    check("reset_changed", int'(speed_changed), 0);

    // Latency of a clean press: speed moves on the 7th rising edge
    p0 = pulse_cnt;
    btn_up = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) begin
        check("lat_speed_e6", int'(speed), 8);
        check("lat_changed_e6", int'(speed_changed), 0);
      end
      if (k == 7) begin
        check("lat_speed_e7", int'(speed), 9);
        check("lat_changed_e7", int'(speed_changed), 1);
      end
    end
    repeat (13) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    model_up();
    check("held_speed", int'(speed), 9);
    check("held_pulses", pulse_cnt - p0, 1);

    // Bouncing button never settles long enough to be accepted
    p0 = pulse_cnt;
    cyc = 0;
    while (cyc < 30) begin
      h = $urandom_range(1, 3);
      l = $urandom_range(1, 3);
      btn_down = 1'b1;
      repeat (h) @(negedge clk);
      btn_down = 1'b0;
      repeat (l) @(negedge clk);
      cyc += h + l;
    end
    repeat (10) @(negedge clk);
    check("bounce_speed", int'(speed), 9);
    check("bounce_pulses", pulse_cnt - p0, 0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      p0 = pulse_cnt;
      for (int r = 0; r < vecs[i].reps; r++) do_unit(vecs[i].op);
      check($sformatf("vec%0d_speed", i), int'(speed), vecs[i].exp_speed);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
      check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
    end

    // Mode press coinciding with a dwell-completing toggle edge
    do_unit(OP_MODE);
    do_unit(OP_TOG);
    check("prio_setup_mode", int'(mode), 1);
    check("prio_setup_speed", int'(speed), 14);
    p0 = pulse_cnt;
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    toggle = ~toggle;
    @(negedge clk);
    check("prio_mode", int'(mode), 0);
    check("prio_speed", int'(speed), 14);
    check("prio_changed", int'(speed_changed), 0);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    model_mode();
    check("prio_pulses", pulse_cnt - p0, 0);

    // Reset mid-sweep with partial dwell and a debounce in progress
    do_unit(OP_MODE);
    do_unit(OP_TOG);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_speed", int'(speed), 8);
    check("midrst_mode", int'(mode), 0);
    check("midrst_changed", int'(speed_changed), 0);
    btn_up = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check("postrst_speed", int'(speed), 8);
    do_unit(OP_MODE);
    do_unit(OP_TOG);
    check("postrst_one_edge", int'(speed), 8);
    do_unit(OP_TOG);
    check("postrst_two_edges", int'(speed), 9);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      int sel;
      int op;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       op = OP_UP;
        1:       op = OP_DOWN;
        2:       op = OP_MODE;
        default: op = OP_TOG;
      endcase
      p0  = pulse_cnt;
      mp0 = m_pulses;
      do_unit(op);
      check($sformatf("rnd%0d_speed", i), int'(speed), m_speed);
      check($sformatf("rnd%0d_mode", i), int'(mode), m_mode);
      check($sformatf("rnd%0d_pulses", i), pulse_cnt - p0, m_pulses - mp0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
